// File: rtl/palette_pkg.sv
// Shared palette definitions: default Material palette, channel-width
// conversion and the sequencer state encoding.
package palette_pkg;

   typedef logic state_t;
   localparam state_t INIT = 1'b0;
   localparam state_t RUN  = 1'b1;

   localparam int DEFAULT_DEPTH = 256;

   // 16 accented hues (50..900, A100..A700), brown/grey/blue grey (50..900), black, white.
   localparam logic [23:0] MATERIAL [DEFAULT_DEPTH] = '{
      24'hffebee, 24'hffcdd2, 24'hef9a9a, 24'he57373, 24'hef5350, 24'hf44336, 24'he53935, 24'hd32f2f, 24'hc62828, 24'hb71c1c, 24'hff8a80, 24'hff5252, 24'hff1744, 24'hd50000,
      24'hfce4ec, 24'hf8bbd0, 24'hf48fb1, 24'hf06292, 24'hec407a, 24'he91e63, 24'hd81b60, 24'hc2185b, 24'had1457, 24'h880e4f, 24'hff80ab, 24'hff4081, 24'hf50057, 24'hc51162,
      24'hf3e5f5, 24'he1bee7, 24'hce93d8, 24'hba68c8, 24'hab47bc, 24'h9c27b0, 24'h8e24aa, 24'h7b1fa2, 24'h6a1b9a, 24'h4a148c, 24'hea80fc, 24'he040fb, 24'hd500f9, 24'haa00ff,
      24'hede7f6, 24'hd1c4e9, 24'hb39ddb, 24'h9575cd, 24'h7e57c2, 24'h673ab7, 24'h5e35b1, 24'h512da8, 24'h4527a0, 24'h311b92, 24'hb388ff, 24'h7c4dff, 24'h651fff, 24'h6200ea,
      24'he8eaf6, 24'hc5cae9, 24'h9fa8da, 24'h7986cb, 24'h5c6bc0, 24'h3f51b5, 24'h3949ab, 24'h303f9f, 24'h283593, 24'h1a237e, 24'h8c9eff, 24'h536dfe, 24'h3d5afe, 24'h304ffe,
      24'he3f2fd, 24'hbbdefb, 24'h90caf9, 24'h64b5f6, 24'h42a5f5, 24'h2196f3, 24'h1e88e5, 24'h1976d2, 24'h1565c0, 24'h0d47a1, 24'h82b1ff, 24'h448aff, 24'h2979ff, 24'h2962ff,
      24'he1f5fe, 24'hb3e5fc, 24'h81d4fa, 24'h4fc3f7, 24'h29b6f6, 24'h03a9f4, 24'h039be5, 24'h0288d1, 24'h0277bd, 24'h01579b, 24'h80d8ff, 24'h40c4ff, 24'h00b0ff, 24'h0091ea,
      24'he0f7fa, 24'hb2ebf2, 24'h80deea, 24'h4dd0e1, 24'h26c6da, 24'h00bcd4, 24'h00acc1, 24'h0097a7, 24'h00838f, 24'h006064, 24'h84ffff, 24'h18ffff, 24'h00e5ff, 24'h00b8d4,
      24'he0f2f1, 24'hb2dfdb, 24'h80cbc4, 24'h4db6ac, 24'h26a69a, 24'h009688, 24'h00897b, 24'h00796b, 24'h00695c, 24'h004d40, 24'ha7ffeb, 24'h64ffda, 24'h1de9b6, 24'h00bfa5,
      24'he8f5e9, 24'hc8e6c9, 24'ha5d6a7, 24'h81c784, 24'h66bb6a, 24'h4caf50, 24'h43a047, 24'h388e3c, 24'h2e7d32, 24'h1b5e20, 24'hb9f6ca, 24'h69f0ae, 24'h00e676, 24'h00c853,
      24'hf1f8e9, 24'hdcedc8, 24'hc5e1a5, 24'haed581, 24'h9ccc65, 24'h8bc34a, 24'h7cb342, 24'h689f38, 24'h558b2f, 24'h33691e, 24'hccff90, 24'hb2ff59, 24'h76ff03, 24'h64dd17,
      24'hf9fbe7, 24'hf0f4c3, 24'he6ee9c, 24'hdce775, 24'hd4e157, 24'hcddc39, 24'hc0ca33, 24'hafb42b, 24'h9e9d24, 24'h827717, 24'hf4ff81, 24'heeff41, 24'hc6ff00, 24'haeea00,
      24'hfffde7, 24'hfff9c4, 24'hfff59d, 24'hfff176, 24'hffee58, 24'hffeb3b, 24'hfdd835, 24'hfbc02d, 24'hf9a825, 24'hf57f17, 24'hffff8d, 24'hffff00, 24'hffea00, 24'hffd600,
      24'hfff8e1, 24'hffecb3, 24'hffe082, 24'hffd54f, 24'hffca28, 24'hffc107, 24'hffb300, 24'hffa000, 24'hff8f00, 24'hff6f00, 24'hffe57f, 24'hffd740, 24'hffc400, 24'hffab00,
      24'hfff3e0, 24'hffe0b2, 24'hffcc80, 24'hffb74d, 24'hffa726, 24'hff9800, 24'hfb8c00, 24'hf57c00, 24'hef6c00, 24'he65100, 24'hffd180, 24'hffab40, 24'hff9100, 24'hff6d00,
      24'hfbe9e7, 24'hffccbc, 24'hffab91, 24'hff8a65, 24'hff7043, 24'hff5722, 24'hf4511e, 24'he64a19, 24'hd84315, 24'hbf360c, 24'hff9e80, 24'hff6e40, 24'hff3d00, 24'hdd2c00,
      24'hefebe9, 24'hd7ccc8, 24'hbcaaa4, 24'ha1887f, 24'h8d6e63, 24'h795548, 24'h6d4c41, 24'h5d4037, 24'h4e342e, 24'h3e2723,
      24'hfafafa, 24'hf5f5f5, 24'heeeeee, 24'he0e0e0, 24'hbdbdbd, 24'h9e9e9e, 24'h757575, 24'h616161, 24'h424242, 24'h212121,
      24'heceff1, 24'hcfd8dc, 24'hb0bec5, 24'h90a4ae, 24'h78909c, 24'h607d8b, 24'h546e7a, 24'h455a64, 24'h37474f, 24'h263238,
      24'h000000, 24'hffffff
   };

   function automatic logic [23:0] default_color(input int unsigned idx);
      logic [23:0] c;
      c = 24'h000000;
      if (idx < 32'(DEFAULT_DEPTH)) c = MATERIAL[idx[7:0]];
      return c;
   endfunction

   // Narrow channels keep the MSBs; wide channels repeat the 8-bit pattern into the LSBs.
   function automatic logic [31:0] conv_ch(input logic [7:0] c8, input int ch);
      logic [31:0] r;
      r = '0;
      if (ch <= 8) begin
         r = 32'(c8 >> (8 - ch));
      end else begin
         for (int b = 0; b < 32; b++) begin
            if (b < ch) r[5'(ch - 1 - b)] = c8[3'(7 - b)];
         end
      end
      return r;
   endfunction

endpackage

// File: rtl/palette_lut_if.sv
// Pixel lookup and host write bus of the palette; master drives codes and
// writes, slave (the palette) returns colours and status.
interface palette_lut_if #(
   parameter int CODE_W = 8,
   parameter int RGB_W  = 24
);
   logic              pix_valid;
   logic [CODE_W-1:0] code;
   logic [1:0]        dim;
   logic              rgb_valid;
   logic [RGB_W-1:0]  rgb;
   logic              wr_en;
   logic [CODE_W-1:0] wr_addr;
   logic [RGB_W-1:0]  wr_data;
   logic              wr_ready;
   logic              busy;

   modport master (
      output pix_valid, code, dim, wr_en, wr_addr, wr_data,
      input  rgb_valid, rgb, wr_ready, busy
   );

   modport slave (
      input  pix_valid, code, dim, wr_en, wr_addr, wr_data,
      output rgb_valid, rgb, wr_ready, busy
   );
endinterface

// File: rtl/palette_ram.sv
// Palette storage: one write port, one registered read port with write-first
// bypass. No reset on storage or read register so it maps onto block RAM.
module palette_ram #(
   parameter int AW = 8,
   parameter int DW = 24
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [DW-1:0] wdata,
   input  logic [AW-1:0] raddr,
   output logic [DW-1:0] rdata
);

   logic [DW-1:0] mem [2**AW];

   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
      if (we && (waddr == raddr)) rdata <= wdata;
      else                        rdata <= mem[raddr];
   end

endmodule

// File: rtl/palette_lut.sv
// Reprogrammable pixel-code to RGB palette with self-loading defaults,
// host write port and per-pixel dimming; two-cycle lookup latency.
//
// state | meaning
// INIT  | loading default palette entry init_cnt each cycle; host writes refused
// RUN   | normal operation; host writes accepted
module palette_lut #(
   parameter int CODE_W = 8,
   parameter int RGB_W  = 24
) (
   input logic          clk,
   input logic          rst_n,
   palette_lut_if.slave bus
);
   import palette_pkg::*;

   localparam int CH = RGB_W / 3;

   state_t            state;
   state_t            state_nxt;
   logic [CODE_W-1:0] init_cnt;
   logic              init_last;

   logic              ram_we;
   logic [CODE_W-1:0] ram_waddr;
   logic [RGB_W-1:0]  ram_wdata;
   logic [RGB_W-1:0]  ram_rdata;

   logic              s1_valid;
   logic              s1_blank;
   logic [1:0]        s1_dim;
   logic [RGB_W-1:0]  s1_color;
   logic [RGB_W-1:0]  dimmed;

   function automatic logic [RGB_W-1:0] default_rgb(input logic [CODE_W-1:0] idx);
      logic [23:0]      c8;
      logic [RGB_W-1:0] r;
      c8 = default_color(32'(idx));
      r  = '0;
      for (int k = 0; k < 3; k++) begin
         r[k*CH +: CH] = CH'(conv_ch(c8[k*8 +: 8], CH));
      end
      return r;
   endfunction

   assign init_last = (init_cnt == {CODE_W{1'b1}});

   // the init counter stops on the last entry instead of wrapping
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= INIT;
         init_cnt <= '0;
      end else begin
         state <= state_nxt;
         if ((state == INIT) && !init_last) init_cnt <= init_cnt + 1'b1;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         INIT:    if (init_last) state_nxt = RUN;
         RUN:     state_nxt = RUN;
         default: state_nxt = INIT;
      endcase
   end

   always_comb begin
      bus.busy     = 1'b1;
      bus.wr_ready = 1'b0;
      ram_we       = 1'b1;
      ram_waddr    = init_cnt;
      ram_wdata    = default_rgb(init_cnt);
      if (state == RUN) begin
         bus.busy     = 1'b0;
         bus.wr_ready = 1'b1;
         ram_we       = bus.wr_en;
         ram_waddr    = bus.wr_addr;
         ram_wdata    = bus.wr_data;
      end
   end

   palette_ram #(
      .AW (CODE_W),
      .DW (RGB_W)
   ) u_ram (
      .clk   (clk),
      .we    (ram_we),
      .waddr (ram_waddr),
      .wdata (ram_wdata),
      .raddr (bus.code),
      .rdata (ram_rdata)
   );

   // lookups issued while loading return black so video timing is kept
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid <= 1'b0;
         s1_blank <= 1'b1;
         s1_dim   <= '0;
      end else begin
         s1_valid <= bus.pix_valid;
         s1_blank <= (state == INIT);
         s1_dim   <= bus.dim;
      end
   end

   assign s1_color = s1_blank ? '0 : ram_rdata;

   for (genvar k = 0; k < 3; k++) begin : g_ch
      assign dimmed[k*CH +: CH] = s1_color[k*CH +: CH] >> s1_dim;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bus.rgb_valid <= 1'b0;
         bus.rgb       <= '0;
      end else begin
         bus.rgb_valid <= s1_valid;
         if (s1_valid) bus.rgb <= dimmed;
      end
   end

endmodule

// File: tb/tb_palette_lut.sv
// Self-checking bench for palette_lut: randomized lookups/writes against a
// behavioural table model plus directed palette, dim, bypass and reset cases.
module tb_palette_lut;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   palette_lut_if #(.CODE_W(8), .RGB_W(24)) if_a ();
   palette_lut_if #(.CODE_W(4), .RGB_W(12)) if_b ();
   palette_lut_if #(.CODE_W(9), .RGB_W(24)) if_c ();

   palette_lut #(.CODE_W(8), .RGB_W(24)) u_a (.clk(clk), .rst_n(rst_n), .bus(if_a.slave));
   palette_lut #(.CODE_W(4), .RGB_W(12)) u_b (.clk(clk), .rst_n(rst_n), .bus(if_b.slave));
   palette_lut #(.CODE_W(9), .RGB_W(24)) u_c (.clk(clk), .rst_n(rst_n), .bus(if_c.slave));

   int checks = 0;
   int errors = 0;

   logic [23:0] mat [256] = '{
      24'hffebee, 24'hffcdd2, 24'hef9a9a, 24'he57373, 24'hef5350, 24'hf44336, 24'he53935, 24'hd32f2f, 24'hc62828, 24'hb71c1c, 24'hff8a80, 24'hff5252, 24'hff1744, 24'hd50000,
      24'hfce4ec, 24'hf8bbd0, 24'hf48fb1, 24'hf06292, 24'hec407a, 24'he91e63, 24'hd81b60, 24'hc2185b, 24'had1457, 24'h880e4f, 24'hff80ab, 24'hff4081, 24'hf50057, 24'hc51162,
      24'hf3e5f5, 24'he1bee7, 24'hce93d8, 24'hba68c8, 24'hab47bc, 24'h9c27b0, 24'h8e24aa, 24'h7b1fa2, 24'h6a1b9a, 24'h4a148c, 24'hea80fc, 24'he040fb, 24'hd500f9, 24'haa00ff,
      24'hede7f6, 24'hd1c4e9, 24'hb39ddb, 24'h9575cd, 24'h7e57c2, 24'h673ab7, 24'h5e35b1, 24'h512da8, 24'h4527a0, 24'h311b92, 24'hb388ff, 24'h7c4dff, 24'h651fff, 24'h6200ea,
      24'he8eaf6, 24'hc5cae9, 24'h9fa8da, 24'h7986cb, 24'h5c6bc0, 24'h3f51b5, 24'h3949ab, 24'h303f9f, 24'h283593, 24'h1a237e, 24'h8c9eff, 24'h536dfe, 24'h3d5afe, 24'h304ffe,
      24'he3f2fd, 24'hbbdefb, 24'h90caf9, 24'h64b5f6, 24'h42a5f5, 24'h2196f3, 24'h1e88e5, 24'h1976d2, 24'h1565c0, 24'h0d47a1, 24'h82b1ff, 24'h448aff, 24'h2979ff, 24'h2962ff,
      24'he1f5fe, 24'hb3e5fc, 24'h81d4fa, 24'h4fc3f7, 24'h29b6f6, 24'h03a9f4, 24'h039be5, 24'h0288d1, 24'h0277bd, 24'h01579b, 24'h80d8ff, 24'h40c4ff, 24'h00b0ff, 24'h0091ea,
      24'he0f7fa, 24'hb2ebf2, 24'h80deea, 24'h4dd0e1, 24'h26c6da, 24'h00bcd4, 24'h00acc1, 24'h0097a7, 24'h00838f, 24'h006064, 24'h84ffff, 24'h18ffff, 24'h00e5ff, 24'h00b8d4,
      24'he0f2f1, 24'hb2dfdb, 24'h80cbc4, 24'h4db6ac, 24'h26a69a, 24'h009688, 24'h00897b, 24'h00796b, 24'h00695c, 24'h004d40, 24'ha7ffeb, 24'h64ffda, 24'h1de9b6, 24'h00bfa5,
      24'he8f5e9, 24'hc8e6c9, 24'ha5d6a7, 24'h81c784, 24'h66bb6a, 24'h4caf50, 24'h43a047, 24'h388e3c, 24'h2e7d32, 24'h1b5e20, 24'hb9f6ca, 24'h69f0ae, 24'h00e676, 24'h00c853,
      24'hf1f8e9, 24'hdcedc8, 24'hc5e1a5, 24'haed581, 24'h9ccc65, 24'h8bc34a, 24'h7cb342, 24'h689f38, 24'h558b2f, 24'h33691e, 24'hccff90, 24'hb2ff59, 24'h76ff03, 24'h64dd17,
      24'hf9fbe7, 24'hf0f4c3, 24'he6ee9c, 24'hdce775, 24'hd4e157, 24'hcddc39, 24'hc0ca33, 24'hafb42b, 24'h9e9d24, 24'h827717, 24'hf4ff81, 24'heeff41, 24'hc6ff00, 24'haeea00,
      24'hfffde7, 24'hfff9c4, 24'hfff59d, 24'hfff176, 24'hffee58, 24'hffeb3b, 24'hfdd835, 24'hfbc02d, 24'hf9a825, 24'hf57f17, 24'hffff8d, 24'hffff00, 24'hffea00, 24'hffd600,
      24'hfff8e1, 24'hffecb3, 24'hffe082, 24'hffd54f, 24'hffca28, 24'hffc107, 24'hffb300, 24'hffa000, 24'hff8f00, 24'hff6f00, 24'hffe57f, 24'hffd740, 24'hffc400, 24'hffab00,
      24'hfff3e0, 24'hffe0b2, 24'hffcc80, 24'hffb74d, 24'hffa726, 24'hff9800, 24'hfb8c00, 24'hf57c00, 24'hef6c00, 24'he65100, 24'hffd180, 24'hffab40, 24'hff9100, 24'hff6d00,
      24'hfbe9e7, 24'hffccbc, 24'hffab91, 24'hff8a65, 24'hff7043, 24'hff5722, 24'hf4511e, 24'he64a19, 24'hd84315, 24'hbf360c, 24'hff9e80, 24'hff6e40, 24'hff3d00, 24'hdd2c00,
      24'hefebe9, 24'hd7ccc8, 24'hbcaaa4, 24'ha1887f, 24'h8d6e63, 24'h795548, 24'h6d4c41, 24'h5d4037, 24'h4e342e, 24'h3e2723,
      24'hfafafa, 24'hf5f5f5, 24'heeeeee, 24'he0e0e0, 24'hbdbdbd, 24'h9e9e9e, 24'h757575, 24'h616161, 24'h424242, 24'h212121,
      24'heceff1, 24'hcfd8dc, 24'hb0bec5, 24'h90a4ae, 24'h78909c, 24'h607d8b, 24'h546e7a, 24'h455a64, 24'h37474f, 24'h263238,
      24'h000000, 24'hffffff
   };

   // reference model of instance A: table contents, loading countdown, 2-stage delay line
   logic [23:0] mem [256];
   int          init_left;
   logic        m_s1_v;
   logic [23:0] m_s1_c;
   logic        m_rgb_v;
   logic [23:0] m_rgb;

   function automatic logic [23:0] dim_color(input logic [23:0] c, input int d);
      int r, g, b;
      r = int'(c[23:16]);
      g = int'(c[15:8]);
      b = int'(c[7:0]);
      return {8'(r >> d), 8'(g >> d), 8'(b >> d)};
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_s1_v    = 1'b0;
      m_s1_c    = '0;
      m_rgb_v   = 1'b0;
      m_rgb     = '0;
      init_left = 256;
      mem       = mat;
   endtask

   task automatic cycle();
      logic        cur_busy;
      logic        acc;
      logic        cur_v;
      logic [23:0] src;
      logic [23:0] cur_c;
      cur_busy = (init_left > 0);
      acc      = if_a.wr_en && !cur_busy;
      cur_v    = if_a.pix_valid;
      src      = (acc && (if_a.wr_addr == if_a.code)) ? if_a.wr_data : mem[if_a.code];
      cur_c    = cur_busy ? 24'h000000 : dim_color(src, int'(if_a.dim));
      @(posedge clk);
      if (m_s1_v) m_rgb = m_s1_c;
      m_rgb_v = m_s1_v;
      m_s1_v  = cur_v;
      m_s1_c  = cur_c;
      if (acc) mem[if_a.wr_addr] = if_a.wr_data;
      if (init_left > 0) init_left--;
      #1;
      chk("rgb_valid", if_a.rgb_valid, m_rgb_v);
      chk("rgb", if_a.rgb, m_rgb);
      chk("busy", if_a.busy, init_left > 0);
      chk("wr_ready", if_a.wr_ready, init_left == 0);
   endtask

   task automatic lookup(input logic [7:0] c, input logic [1:0] d);
      if_a.pix_valid = 1'b1;
      if_a.code      = c;
      if_a.dim       = d;
      cycle();
      if_a.pix_valid = 1'b0;
      cycle();
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: observed timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int n;
      int a_len, b_len, c_len;

      if_a.pix_valid = 0; if_a.code = '0; if_a.dim = '0; if_a.wr_en = 0; if_a.wr_addr = '0; if_a.wr_data = '0;
      if_b.pix_valid = 0; if_b.code = '0; if_b.dim = '0; if_b.wr_en = 0; if_b.wr_addr = '0; if_b.wr_data = '0;
      if_c.pix_valid = 0; if_c.code = '0; if_c.dim = '0; if_c.wr_en = 0; if_c.wr_addr = '0; if_c.wr_data = '0;
      model_reset();

      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_rgb_valid", if_a.rgb_valid, 1'b0);
      chk("rst_rgb", if_a.rgb, 24'h000000);
      chk("rst_busy", if_a.busy, 1'b1);
      chk("rst_wr_ready", if_a.wr_ready, 1'b0);
      chk("rst_b_busy", if_b.busy, 1'b1);

      // loading window: random lookups must come back black; a host write must be refused
      @(negedge clk);
      rst_n = 1'b1;
      n = 0; a_len = 0; b_len = 0; c_len = 0;
      while ((c_len == 0) && (n < 700)) begin
         if_a.pix_valid = 1'($urandom_range(0, 1));
         if_a.code      = 8'($urandom);
         if_a.dim       = 2'($urandom);
         if_a.wr_en     = (n == 200);
         if_a.wr_addr   = 8'h07;
         if_a.wr_data   = 24'habcdef;
         cycle();
         n++;
         if ((a_len == 0) && !if_a.busy) a_len = n;
         if ((b_len == 0) && !if_b.busy) b_len = n;
         if ((c_len == 0) && !if_c.busy) c_len = n;
      end
      if_a.wr_en = 1'b0;
      if_a.pix_valid = 1'b0;
      chk("init_len_a", a_len, 256);
      chk("init_len_b", b_len, 16);
      chk("init_len_c", c_len, 512);
      cycle();
      cycle();

      lookup(8'h07, 2'd0);
      chk("init_write_refused", if_a.rgb, 24'hd32f2f);

      for (int i = 0; i < 256; i++) begin
         if_a.pix_valid = 1'b1;
         if_a.code      = 8'(i);
         if_a.dim       = 2'd0;
         cycle();
      end
      if_a.pix_valid = 1'b0;
      cycle();
      cycle();

      lookup(8'h00, 2'd0); chk("code_00", if_a.rgb, 24'hffebee);
      lookup(8'hfe, 2'd0); chk("code_fe", if_a.rgb, 24'h000000);
      lookup(8'hff, 2'd0); chk("code_ff", if_a.rgb, 24'hffffff);
      lookup(8'hff, 2'd2); chk("dim2_ff", if_a.rgb, 24'h3f3f3f);
      lookup(8'h05, 2'd1); chk("dim1_05", if_a.rgb, 24'h7a211b);
      lookup(8'h05, 2'd3); chk("dim3_05", if_a.rgb, 24'h1e0806);

      for (int i = 0; i < 64; i++) begin
         if_a.pix_valid = 1'b1;
         if_a.code      = 8'($urandom);
         if_a.dim       = 2'(i);
         cycle();
      end
      if_a.pix_valid = 1'b0;
      cycle();
      cycle();

      // same-cycle write and lookup of one address
      if_a.wr_en     = 1'b1;
      if_a.wr_addr   = 8'h05;
      if_a.wr_data   = 24'h123456;
      if_a.pix_valid = 1'b1;
      if_a.code      = 8'h05;
      if_a.dim       = 2'd0;
      cycle();
      if_a.wr_en     = 1'b0;
      if_a.pix_valid = 1'b0;
      cycle();
      chk("bypass_05", if_a.rgb, 24'h123456);
      lookup(8'h06, 2'd0); chk("neighbour_06", if_a.rgb, 24'he53935);
      lookup(8'h05, 2'd0); chk("persist_05", if_a.rgb, 24'h123456);

      for (int i = 0; i < 200; i++) begin
         if_a.wr_en     = ($urandom_range(0, 3) == 0);
         if_a.wr_addr   = 8'($urandom_range(0, 15));
         if_a.wr_data   = 24'($urandom);
         if_a.pix_valid = 1'($urandom_range(0, 1));
         if_a.code      = 8'($urandom_range(0, 15));
         if_a.dim       = 2'($urandom);
         cycle();
      end
      if_a.wr_en     = 1'b0;
      if_a.pix_valid = 1'b0;
      cycle();
      cycle();

      if_b.pix_valid = 1'b1; if_b.code = 4'h5;
      if_c.pix_valid = 1'b1; if_c.code = 9'h0ff;
      cycle();
      if_b.pix_valid = 1'b0;
      if_c.code = 9'h100;
      cycle();
      chk("b_code5", if_b.rgb, 12'hf43);
      chk("b_valid", if_b.rgb_valid, 1'b1);
      chk("c_code0ff", if_c.rgb, 24'hffffff);
      if_c.pix_valid = 1'b0;
      cycle();
      chk("c_code100", if_c.rgb, 24'h000000);

      // rewrite entry 0, then reset in the middle of a pixel stream
      if_a.wr_en   = 1'b1;
      if_a.wr_addr = 8'h00;
      if_a.wr_data = 24'h555555;
      cycle();
      if_a.wr_en = 1'b0;
      lookup(8'h00, 2'd0); chk("rewrite_00", if_a.rgb, 24'h555555);
      for (int i = 0; i < 4; i++) begin
         if_a.pix_valid = 1'b1;
         if_a.code      = 8'($urandom);
         if_a.dim       = 2'd0;
         cycle();
      end
      chk("stream_valid", if_a.rgb_valid, 1'b1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("midrst_rgb_valid", if_a.rgb_valid, 1'b0);
      chk("midrst_rgb", if_a.rgb, 24'h000000);
      chk("midrst_busy", if_a.busy, 1'b1);
      chk("midrst_wr_ready", if_a.wr_ready, 1'b0);
      model_reset();
      if_a.pix_valid = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      n = 0;
      a_len = 0;
      while ((a_len == 0) && (n < 300)) begin
         cycle();
         n++;
         if (!if_a.busy) a_len = n;
      end
      chk("reinit_len", a_len, 256);
      lookup(8'h00, 2'd0); chk("reinit_00", if_a.rgb, 24'hffebee);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
